// File: rtl/accum_stage_if.sv
// Stream, adder and result signals between accum_stage and its neighbours.
// The slave view belongs to accum_stage; the master view is its environment.
interface accum_stage_if #(
  parameter int N       = 4,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_data;
  logic               in_last;

  logic [N-1:0]       add_a;
  logic [N-1:0]       add_b;
  logic [N-1:0]       add_sum;
  logic               add_carry;
  logic               add_overflow;
  logic               add_parity;
  logic               add_zero;
  logic               add_sign;

  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_sum;
  logic               out_carry;
  logic               out_overflow;
  logic               out_zero;
  logic               out_sign;
  logic               out_parity;
  logic [COUNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last,
    input  add_sum, add_carry, add_overflow,
    input  add_parity, add_zero, add_sign,
    input  out_ready,
    output in_ready, add_a, add_b,
    output out_valid, out_sum, out_carry,
    output out_overflow, out_zero, out_sign,
    output out_parity, out_count
  );

  modport master (
    output in_valid, in_data, in_last,
    output add_sum, add_carry, add_overflow,
    output add_parity, add_zero, add_sign,
    output out_ready,
    input  in_ready, add_a, add_b,
    input  out_valid, out_sum, out_carry,
    input  out_overflow, out_zero, out_sign,
    input  out_parity, out_count
  );
endinterface

// File: rtl/accum_stage.sv
// Burst accumulator around an external combinational flag adder.
// Holds one registered result with sticky carry/overflow until taken.
module accum_stage #(
  parameter int N       = 4,
  parameter int COUNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  accum_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [N-1:0]       acc_q;
  logic               carry_q;
  logic               ovf_q;
  logic [COUNT_W-1:0] cnt_q;

  logic               out_valid_q;
  logic [N-1:0]       out_sum_q;
  logic               out_carry_q;
  logic               out_ovf_q;
  logic               out_zero_q;
  logic               out_sign_q;
  logic               out_parity_q;
  logic [COUNT_W-1:0] out_count_q;

  logic               xfer;
  logic               pop;
  logic               carry_d;
  logic               ovf_d;
  logic [COUNT_W-1:0] cnt_d;

  assign bus.in_ready = !rst && (state_q != DONE);
  assign xfer = bus.in_valid && bus.in_ready;
  assign pop  = out_valid_q && bus.out_ready;

  assign carry_d = carry_q | bus.add_carry;
  assign ovf_d   = ovf_q | bus.add_overflow;
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // acc_q is zero in IDLE, so the first operand lands unchanged
  assign bus.add_a = acc_q;
  assign bus.add_b = bus.in_data;

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_carry    = out_carry_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_sign     = out_sign_q;
  assign bus.out_parity   = out_parity_q;
  assign bus.out_count    = out_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_carry_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_zero_q   <= 1'b0;
      out_sign_q   <= 1'b0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (xfer) begin
            acc_q   <= bus.add_sum;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            if (bus.in_last) begin
              state_q      <= DONE;
              out_valid_q  <= 1'b1;
              out_sum_q    <= bus.add_sum;
              out_carry_q  <= carry_d;
              out_ovf_q    <= ovf_d;
              out_zero_q   <= bus.add_zero;
              out_sign_q   <= bus.add_sign;
              out_parity_q <= bus.add_parity;
              out_count_q  <= cnt_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (pop) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_stage.sv
// Bench for accum_stage: behavioural adder, vector table, corner
// sequences and random bursts against an integer reference model.
module tb_accum_stage;

  logic clk;
  logic rst;

  int checks;
  int errors;

  accum_stage_if #(.N(4), .COUNT_W(8)) bus ();
  accum_stage_if #(.N(4), .COUNT_W(2)) bus2 ();

  accum_stage #(.N(4), .COUNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  accum_stage #(.N(4), .COUNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sum;
    logic       c;
    logic       v;
    logic       z;
    logic       s;
    logic       p;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       c;
    logic       v;
    logic       p;
    logic       z;
    logic       s;
  } add_t;

  typedef struct {
    int              n;
    logic [4:0][3:0] d;
    exp_t            e;
  } vec_t;

  // the external adder the block is wired to
  function automatic add_t add4(input logic [3:0] a, input logic [3:0] b);
    add_t r;
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b};
    r.sum = t[3:0];
    r.c = t[4];
    r.v = (a[3] == b[3]) && (t[3] != a[3]);
    r.p = ~^t[3:0];
    r.z = (t[3:0] == 4'd0);
    r.s = t[3];
    return r;
  endfunction

  assign {bus.add_sum, bus.add_carry, bus.add_overflow,
          bus.add_parity, bus.add_zero, bus.add_sign}
    = add4(bus.add_a, bus.add_b);
  assign {bus2.add_sum, bus2.add_carry, bus2.add_overflow,
          bus2.add_parity, bus2.add_zero, bus2.add_sign}
    = add4(bus2.add_a, bus2.add_b);

  function automatic int sx(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // reference: integer running total with unsigned/signed range tests
  function automatic exp_t model(input int n, input int d[16], input int cmax);
    exp_t e;
    int acc;
    int u;
    int sg;
    int ones;
    e = '0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      u = acc + d[i];
      sg = sx(acc) + sx(d[i]);
      if (u > 15) e.c = 1'b1;
      if (sg > 7 || sg < -8) e.v = 1'b1;
      acc = u % 16;
    end
    ones = 0;
    for (int b = 0; b < 4; b++) ones += (acc >> b) & 1;
    e.sum = acc[3:0];
    e.z = (acc == 0);
    e.s = (acc >= 8);
    e.p = (ones % 2 == 0);
    e.cnt = 8'((n > cmax) ? cmax : n);
    return e;
  endfunction

  function automatic vec_t mk(input int n, input logic [3:0] d0,
      input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
      input logic [3:0] sum, input logic c, input logic v, input logic z,
      input logic s, input logic p, input logic [7:0] cnt);
    vec_t t;
    t.n = n;
    t.d = '0;
    t.d[0] = d0;
    t.d[1] = d1;
    t.d[2] = d2;
    t.d[3] = d3;
    t.e = '{sum: sum, c: c, v: v, z: z, s: s, p: p, cnt: cnt};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic check_out(input exp_t e, input string nm);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_sum"}, 32'(bus.out_sum), 32'(e.sum));
    chk({nm, "_carry"}, 32'(bus.out_carry), 32'(e.c));
    chk({nm, "_ovf"}, 32'(bus.out_overflow), 32'(e.v));
    chk({nm, "_zero"}, 32'(bus.out_zero), 32'(e.z));
    chk({nm, "_sign"}, 32'(bus.out_sign), 32'(e.s));
    chk({nm, "_parity"}, 32'(bus.out_parity), 32'(e.p));
    chk({nm, "_count"}, 32'(bus.out_count), 32'(e.cnt));
  endtask

  task automatic pop(input string nm);
    @(negedge clk);
    bus.out_ready = 1'b1;
    chk({nm, "_bubble_ready"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_popped_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_burst(input int n, input int d[16], input exp_t e,
      input string nm, input int gmax, input int hmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) @(negedge clk);
      send(d[i][3:0], i == n - 1);
    end
    @(negedge clk);
    check_out(e, nm);
    repeat ($urandom_range(0, hmax)) @(negedge clk);
    pop(nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   d[16];
    exp_t e;
    int   n;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data = '0;
    bus2.in_last = 1'b0;
    bus2.out_ready = 1'b0;

    tbl[0] = mk(3, 4'h3, 4'h4, 4'h5, 4'h0, 4'hC, 0, 1, 0, 1, 1, 8'd3);
    tbl[1] = mk(2, 4'h9, 4'h9, 4'h0, 4'h0, 4'h2, 1, 1, 0, 0, 0, 8'd2);
    tbl[2] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 1, 8'd1);
    tbl[3] = mk(2, 4'h2, 4'h3, 4'h0, 4'h0, 4'h5, 0, 0, 0, 0, 1, 8'd2);
    tbl[4] = mk(2, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 1, 0, 1, 0, 1, 8'd2);
    tbl[5] = mk(2, 4'h7, 4'h1, 4'h0, 4'h0, 4'h8, 0, 1, 0, 1, 0, 8'd2);
    tbl[6] = mk(4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 1, 1, 1, 0, 1, 8'd4);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (tbl[i]) begin
      d = '{default: 0};
      for (int k = 0; k < tbl[i].n; k++) d[k] = int'(tbl[i].d[k]);
      run_burst(tbl[i].n, d, tbl[i].e, $sformatf("vec%0d", i), 0, 0);
    end

    // stalled result: input offered but must be ignored
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b1);
    @(negedge clk);
    check_out(tbl[0].e, "hold0");
    bus.in_valid = 1'b1;
    bus.in_data = 4'h7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sum", 32'(bus.out_sum), 32'hC);
      chk("hold_count", 32'(bus.out_count), 32'd3);
      chk("hold_ovf", 32'(bus.out_overflow), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_acc", 32'(bus.add_a), 32'hC);
    end
    bus.in_valid = 1'b0;
    pop("hold");
    d = '{default: 0};
    d[0] = 1;
    run_burst(1, d, model(1, d, 255), "after_hold", 0, 0);

    // reset mid-burst discards the partial sum
    send(4'h2, 1'b0);
    send(4'h2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    d = '{default: 0};
    d[0] = 1;
    e = '{sum: 4'h1, c: 0, v: 0, z: 0, s: 0, p: 0, cnt: 8'd1};
    run_burst(1, d, e, "post_rst", 0, 0);

    // saturating count on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sat_in_ready", 32'(bus2.in_ready), 32'd1);
      bus2.in_valid = 1'b1;
      bus2.in_data = 4'h1;
      bus2.in_last = (i == 4);
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      bus2.in_last = 1'b0;
    end
    @(negedge clk);
    chk("sat_valid", 32'(bus2.out_valid), 32'd1);
    chk("sat_count", 32'(bus2.out_count), 32'd3);
    chk("sat_sum", 32'(bus2.out_sum), 32'd5);
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b0;
    @(negedge clk);
    chk("sat_popped", 32'(bus2.out_valid), 32'd0);

    // random bursts with gaps and downstream back-pressure
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 8);
      d = '{default: 0};
      for (int k = 0; k < n; k++) d[k] = $urandom_range(0, 15);
      run_burst(n, d, model(n, d, 255), $sformatf("rnd%0d", r), 2, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
